// File: rtl/sm_pkg.sv
// -----------------------------------------------------------------------------
// sm_pkg
// Shared definitions for the sign-magnitude add/subtract pipeline.
//
// Contents:
//   SM_MAX_W       widest supported operand width (sign + magnitude)
//   s1_t           contents of the first pipeline stage register
//   sm_mag_mask    mask selecting the magnitude bits of an n-bit word
//   sm_sign        extract the sign bit of an n-bit sign-magnitude word
//   sm_mag         extract the magnitude bits of an n-bit sign-magnitude word
//   sm_norm_zero   rebuild an n-bit word from sign and magnitude, forcing
//                  a zero magnitude to +0 so -0 never leaves a helper
//
// Packages cannot take parameters. The helpers therefore work on words
// zero-extended to SM_MAX_W bits and take the real width n as an argument.
// The stage struct is sized for the widest case. Callers slice out the low
// bits they need.
// -----------------------------------------------------------------------------
package sm_pkg;

  localparam int SM_MAX_W = 32;

  // First-stage record: effective signs, the magnitude comparison and the
  // operands already put in (larger, smaller) order. The second stage can
  // then always add or subtract without another compare.
  typedef struct packed {
    logic                sign_a;
    logic                sign_b_eff;
    logic                a_ge_b;
    logic [SM_MAX_W-1:0] mag_big;
    logic [SM_MAX_W-1:0] mag_small;
  } s1_t;

  function automatic logic [SM_MAX_W-1:0] sm_mag_mask(input int n);
    return (32'h1 << (n - 1)) - 32'h1;
  endfunction

  function automatic logic sm_sign(input logic [SM_MAX_W-1:0] v, input int n);
    return |(v & (32'h1 << (n - 1)));
  endfunction

  function automatic logic [SM_MAX_W-1:0] sm_mag(input logic [SM_MAX_W-1:0] v,
                                                 input int n);
    return v & sm_mag_mask(n);
  endfunction

  // The sign bit is set only when the magnitude is non-zero. Every result
  // and every normalized operand is therefore +0 rather than -0.
  function automatic logic [SM_MAX_W-1:0] sm_norm_zero(input logic s,
                                                       input logic [SM_MAX_W-1:0] m,
                                                       input int n);
    logic [SM_MAX_W-1:0] mc;
    logic [SM_MAX_W-1:0] word;
    mc   = m & sm_mag_mask(n);
    word = mc;
    if (s && (mc != '0)) begin
      word = mc | (32'h1 << (n - 1));
    end
    return word;
  endfunction

endpackage

// File: rtl/sm_mag_alu.sv
// -----------------------------------------------------------------------------
// sm_mag_alu
// Combinational unsigned magnitude unit used by both pipeline stages.
//
// Parameters:
//   W        magnitude width (operand width minus the sign bit)
// Ports:
//   a, b     input  W   unsigned magnitudes
//   sum      output W   low W bits of a + b
//   carry    output 1   carry out of a + b (magnitude overflow)
//   diff     output W   a - b (meaningful when a >= b)
//   a_ge_b   output 1   a >= b
// -----------------------------------------------------------------------------
module sm_mag_alu
  import sm_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic [W-1:0] diff,
  output logic         a_ge_b
);

  logic [W:0] sum_full;

  // One extra bit on the adder captures the carry that drives saturation.
  always_comb begin
    sum_full = {1'b0, a} + {1'b0, b};
    sum      = sum_full[W-1:0];
    carry    = sum_full[W];
    diff     = a - b;
    a_ge_b   = (a >= b);
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// -----------------------------------------------------------------------------
// sm_addsub_pipe
// Two-stage sign-magnitude adder/subtractor with valid/ready handshakes on
// both sides. A magnitude overflow saturates to all-ones and sets ovf.
//
// Parameters:
//   N          total width (sign in bit N-1), 2..32
// Ports:
//   clk        input  1   clock, rising edge
//   rst        input  1   synchronous active-high reset
//   in_valid   input  1   op_a/op_b/sub are valid
//   in_ready   output 1   an input is accepted this cycle
//   op_a       input  N   operand A, sign-magnitude
//   op_b       input  N   operand B, sign-magnitude
//   sub        input  1   0: A+B, 1: A-B
//   out_valid  output 1   res/ovf are valid
//   out_ready  input  1   the consumer takes the result this cycle
//   res        output N   result, sign-magnitude, never -0
//   ovf        output 1   saturated result (only while out_valid)
//
// Stage 1 registers the effective signs, the comparison and the ordered
// magnitudes. Stage 2 registers res/ovf. Each stage loads whenever it is
// empty or its contents move downstream in the same cycle. This collapses
// bubbles and gives a 2-deep buffer under backpressure.
// -----------------------------------------------------------------------------
module sm_addsub_pipe
  import sm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         ovf
);

  localparam int W = N - 1;

  logic [SM_MAX_W-1:0] a_ext;
  logic [SM_MAX_W-1:0] b_ext;
  logic [SM_MAX_W-1:0] a_norm;
  logic [SM_MAX_W-1:0] b_norm;
  logic [SM_MAX_W-1:0] a_mag_full;
  logic [SM_MAX_W-1:0] b_mag_full;
  logic [W-1:0]        a_mag;
  logic [W-1:0]        b_mag;
  logic                a_sign;
  logic                b_sign_eff;

  logic                cmp_a_ge_b;
  logic [W-1:0]        cmp_sum_unused;
  logic [W-1:0]        cmp_diff_unused;
  logic                cmp_carry_unused;

  s1_t                 s1_d;
  s1_t                 s1_q;
  logic                s1_valid;

  logic [W-1:0]        big_q;
  logic [W-1:0]        small_q;
  logic [W-1:0]        alu_sum;
  logic [W-1:0]        alu_diff;
  logic                alu_carry;
  logic                alu_ge_unused;

  logic                same_sign;
  logic                res_sign;
  logic [W-1:0]        res_mag;
  logic [SM_MAX_W-1:0] res_mag_full;
  logic [SM_MAX_W-1:0] res_full;
  logic [N-1:0]        res_d;
  logic                ovf_d;

  logic                s2_valid;
  logic [N-1:0]        res_q;
  logic                ovf_q;
  logic                s2_advance;
  logic                unused_bits;

  // Bring both operands into helper width and normalize -0 to +0 first.
  // Subtraction is folded into B's sign, so stage 2 sees only an
  // add-or-subtract-magnitudes decision.
  always_comb begin
    a_ext      = SM_MAX_W'(op_a);
    b_ext      = SM_MAX_W'(op_b);
    a_norm     = sm_norm_zero(sm_sign(a_ext, N), sm_mag(a_ext, N), N);
    b_norm     = sm_norm_zero(sm_sign(b_ext, N), sm_mag(b_ext, N), N);
    a_mag_full = sm_mag(a_norm, N);
    b_mag_full = sm_mag(b_norm, N);
    a_mag      = a_mag_full[W-1:0];
    b_mag      = b_mag_full[W-1:0];
    a_sign     = sm_sign(a_norm, N);
    b_sign_eff = sm_sign(b_norm, N) ^ sub;
  end

  // Stage-1 comparator; only the ordering output is used here.
  sm_mag_alu #(.W(W)) u_cmp_alu (
    .a      (a_mag),
    .b      (b_mag),
    .sum    (cmp_sum_unused),
    .carry  (cmp_carry_unused),
    .diff   (cmp_diff_unused),
    .a_ge_b (cmp_a_ge_b)
  );

  // Build the stage-1 record. The magnitudes are ordered so that stage 2
  // subtracts in only one direction.
  always_comb begin
    s1_d                      = '0;
    s1_d.sign_a               = a_sign;
    s1_d.sign_b_eff           = b_sign_eff;
    s1_d.a_ge_b               = cmp_a_ge_b;
    s1_d.mag_big[W-1:0]       = cmp_a_ge_b ? a_mag : b_mag;
    s1_d.mag_small[W-1:0]     = cmp_a_ge_b ? b_mag : a_mag;
  end

  assign big_q   = s1_q.mag_big[W-1:0];
  assign small_q = s1_q.mag_small[W-1:0];

  // Stage-2 arithmetic on the ordered magnitudes.
  sm_mag_alu #(.W(W)) u_res_alu (
    .a      (big_q),
    .b      (small_q),
    .sum    (alu_sum),
    .carry  (alu_carry),
    .diff   (alu_diff),
    .a_ge_b (alu_ge_unused)
  );

  // With matching signs, add and saturate on carry while keeping the common
  // sign. With different signs, subtract smaller from larger and take the
  // larger operand's sign. Equal magnitudes give zero, which the normalize
  // step turns into +0.
  always_comb begin
    same_sign    = (s1_q.sign_a == s1_q.sign_b_eff);
    res_sign     = 1'b0;
    res_mag      = '0;
    ovf_d        = 1'b0;
    if (same_sign) begin
      res_sign = s1_q.sign_a;
      if (alu_carry) begin
        res_mag = '1;
        ovf_d   = 1'b1;
      end else begin
        res_mag = alu_sum;
      end
    end else begin
      res_sign = s1_q.a_ge_b ? s1_q.sign_a : s1_q.sign_b_eff;
      res_mag  = alu_diff;
    end
    res_mag_full = SM_MAX_W'(res_mag);
    res_full     = sm_norm_zero(res_sign, res_mag_full, N);
    res_d        = res_full[N-1:0];
  end

  // Stage 2 can take new data when empty or when its result leaves this
  // cycle. Stage 1 follows the same rule one level up. in_ready is held low
  // during reset.
  always_comb begin
    s2_advance = !s2_valid || out_ready;
    in_ready   = !rst && (!s1_valid || s2_advance);
  end

  // Pipeline registers. A bubble moving into stage 2 clears res/ovf, so
  // they read as zero whenever out_valid is low. While stage 2 is stalled,
  // its outputs are simply not written and stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
      if (s2_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          res_q <= res_d;
          ovf_q <= ovf_d;
        end else begin
          res_q <= '0;
          ovf_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign res       = res_q;
  assign ovf       = ovf_q & s2_valid;

  // The helpers work at the widest size. Bits above the real width are
  // always zero and are gathered here only so they are visibly consumed.
  assign unused_bits = ^{a_mag_full >> W, b_mag_full >> W,
                         s1_q.mag_big >> W, s1_q.mag_small >> W,
                         res_full >> N};

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_sm_addsub_pipe
// Self-checking bench for sm_addsub_pipe at N=4. A table of hand-computed
// vectors is run one at a time and then streamed back to back. Directed
// sequences cover reset, backpressure and reset with ops in flight.
// -----------------------------------------------------------------------------
module tb_sm_addsub_pipe;

  localparam int NV = 14;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [3:0] res;
    logic       ovf;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] res;
  logic       ovf;

  int   compared;
  int   mismatched;
  vec_t vecs[NV];
  vec_t bp[3];

  sm_addsub_pipe #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .ovf       (ovf)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic s);
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
  endtask

  // Vector fields: a, b, sub, expected res, expected ovf.
  initial begin
    vecs[0]  = '{4'b1111, 4'b0110, 1'b0, 4'b1001, 1'b0}; // -7 + 6 = -1
    vecs[1]  = '{4'b0111, 4'b0101, 1'b0, 4'b0111, 1'b1}; // 7 + 5 saturates
    vecs[2]  = '{4'b1111, 4'b0001, 1'b1, 4'b1111, 1'b1}; // -7 - 1 saturates
    vecs[3]  = '{4'b1011, 4'b1011, 1'b1, 4'b0000, 1'b0}; // -3 - -3 = +0
    vecs[4]  = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0}; // -0 + 0 = +0
    vecs[5]  = '{4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0}; // 3 + 2 = 5
    vecs[6]  = '{4'b0010, 4'b0101, 1'b1, 4'b1011, 1'b0}; // 2 - 5 = -3
    vecs[7]  = '{4'b1100, 4'b0011, 1'b0, 4'b1001, 1'b0}; // -4 + 3 = -1
    vecs[8]  = '{4'b0100, 4'b0011, 1'b0, 4'b0111, 1'b0}; // 4 + 3 = 7
    vecs[9]  = '{4'b1100, 4'b0100, 1'b1, 4'b1111, 1'b1}; // -4 - 4 saturates
    vecs[10] = '{4'b0101, 4'b1101, 1'b0, 4'b0000, 1'b0}; // 5 + -5 = +0
    vecs[11] = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0}; // -0 - -0 = +0
    vecs[12] = '{4'b0000, 4'b1010, 1'b1, 4'b0010, 1'b0}; // 0 - -2 = 2
    vecs[13] = '{4'b1001, 4'b0000, 1'b1, 4'b1001, 1'b0}; // -1 - 0 = -1

    bp[0] = '{4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0};    // 3 + 2 = 5
    bp[1] = '{4'b0010, 4'b0101, 1'b1, 4'b1011, 1'b0};    // 2 - 5 = -3
    bp[2] = '{4'b0111, 4'b0101, 1'b0, 4'b0111, 1'b1};    // 7 + 5 saturates
  end

  initial begin
    int tx;
    int rx;
    int done_cyc;
    int accepted;
    int idx;
    logic c_go;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    op_a       = '0;
    op_b       = '0;
    sub        = 1'b0;
    out_ready  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_res", 32'(res), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Isolated vectors: check the 2-cycle latency and each result.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s);
      #1;
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_res", i), 32'(res), 32'(vecs[i].res));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
    end
    @(negedge clk);

    // Streamed vectors: one op per cycle, results in order.
    tx       = 0;
    rx       = 0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 60 && rx < NV; cyc++) begin
      if (out_valid) begin
        checkOutput($sformatf("stream%0d_res", rx), 32'(res), 32'(vecs[rx].res));
        checkOutput($sformatf("stream%0d_ovf", rx), 32'(ovf), 32'(vecs[rx].ovf));
        rx++;
        if (rx == NV) done_cyc = cyc;
      end
      if (tx < NV) begin
        applyStimulus(vecs[tx].a, vecs[tx].b, vecs[tx].s);
        #1;
        if (in_ready) tx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("stream_count", 32'(rx), 32'(NV));
    checkOutput("stream_cycles", 32'(done_cyc), 32'(NV + 1));
    @(negedge clk);

    // Backpressure: two ops fill the pipe, the third waits.
    out_ready = 1'b0;
    accepted  = 0;
    applyStimulus(bp[0].a, bp[0].b, bp[0].s);
    #1;
    if (in_ready) accepted++;
    @(negedge clk);
    applyStimulus(bp[1].a, bp[1].b, bp[1].s);
    #1;
    if (in_ready) accepted++;
    @(negedge clk);
    applyStimulus(bp[2].a, bp[2].b, bp[2].s);
    #1;
    checkOutput("bp_accepted", 32'(accepted), 32'd2);
    checkOutput("bp_in_ready_drop", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_res_first", 32'(res), 32'(bp[0].res));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_res", k), 32'(res), 32'(bp[0].res));
      checkOutput($sformatf("bp_hold%0d_ovf", k), 32'(ovf), 32'(bp[0].ovf));
    end

    // Release: the first result leaves while the waiting op enters.
    out_ready = 1'b1;
    idx       = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      #1;
      if (out_valid) begin
        checkOutput($sformatf("bp_drain%0d_res", idx), 32'(res), 32'(bp[idx].res));
        checkOutput($sformatf("bp_drain%0d_ovf", idx), 32'(ovf), 32'(bp[idx].ovf));
        idx++;
      end
      c_go = in_valid && in_ready;
      @(negedge clk);
      if (c_go) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput("bp_drain_count", 32'(idx), 32'd3);
    @(negedge clk);
    checkOutput("bp_no_extra", 32'(out_valid), 32'd0);

    // Reset pulse with two ops in flight.
    out_ready = 1'b0;
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0010, 4'b0001, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("rst_mid_setup_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_res", 32'(res), 32'd0);
    checkOutput("rst_mid_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_mid_stale%0d", k), 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sm_addsub_pipe.md
SM_ADDSUB_PIPE -- requirements
Module: sm_addsub_pipe

Interface
REQ-001 Parameter N SHALL default to 4; it is the total operand/result width, sign in bit N-1 and magnitude in bits N-2:0, legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset; synchronous, active-high.
REQ-004 in_valid  input  1  SHALL mark op_a/op_b/sub as valid this cycle.
REQ-005 in_ready  output  1  SHALL indicate that the block accepts an input this cycle.
REQ-006 op_a  input  N  SHALL be operand A in sign-magnitude.
REQ-007 op_b  input  N  SHALL be operand B in sign-magnitude.
REQ-008 sub  input  1  SHALL select the operation: 0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  SHALL mark res/ovf as valid.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-011 res  output  N  SHALL be the sign-magnitude result.
REQ-012 ovf  output  1  SHALL flag magnitude overflow (saturated result).

Function
REQ-013 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer on a cycle with out_valid && out_ready.
REQ-014 Pipeline SHALL be 2 stages: S1 registers the effective sign of B (op_b[N-1]^sub), the magnitude comparison and the operand order; S2 registers res/ovf.
REQ-015 Latency SHALL be 2 cycles from an input transfer to out_valid when there is no backpressure; throughput SHALL be 1 op/cycle.
REQ-016 A stage SHALL load when it is empty or its contents transfer downstream in the same cycle; in_ready = !S1_valid || S1 advancing.
REQ-017 Under backpressure (out_valid && !out_ready), res/ovf/out_valid SHALL hold stable, and bubbles SHALL collapse so that 2 ops are stored before in_ready drops.
REQ-018 Equal effective signs: magnitude SHALL be |A|+|B| and sign SHALL be the common sign.
REQ-019 On carry out of N-1 bits, the magnitude SHALL saturate to all-ones, keeping that sign, with ovf=1.
REQ-020 Differing effective signs: result SHALL be larger magnitude minus smaller, sign of the larger operand, ovf=0.
REQ-021 Equal magnitudes with differing signs SHALL yield +0 (all zeros).
REQ-022 A -0 input SHALL be treated as +0; res SHALL never be -0 (sign forced to 0 when the magnitude is 0).
REQ-023 ovf SHALL be valid only with out_valid; it SHALL be 0 otherwise.
REQ-024 Simultaneous output transfer and input transfer with a full pipe SHALL lose and duplicate no operation.

Reset
REQ-025 While rst=1: out_valid=0, ovf=0, res=0, both stage valids=0, in_ready=0.
REQ-026 in_ready SHALL rise the first cycle after rst deasserts.
REQ-027 rst asserted mid-operation SHALL discard all in-flight ops; no stale out_valid after reset.

Structure
REQ-028 Package sm_pkg SHALL hold the sign-magnitude helper functions (sign, magnitude, normalize-zero) and the S1 struct typedef, parametrised by N via function arguments/widths.
REQ-029 One sub-module, sm_mag_alu (combinational magnitude add/sub with carry and compare), SHALL be instantiated by S1/S2; all registers SHALL stay in sm_addsub_pipe.

Verification (N=4)
REQ-030 op_a=1111 (-7), op_b=0110 (+6), sub=0 -> res=1001 (-1), ovf=0, out_valid 2 cycles after the input transfer.
REQ-031 op_a=0111 (+7), op_b=0101 (+5), sub=0 -> res=0111, ovf=1; op_a=1111, op_b=0001, sub=1 -> res=1111, ovf=1.
REQ-032 op_a=1011 (-3), op_b=1011, sub=1 -> res=0000 (+0, not 1000); op_a=1000, op_b=0000 -> res=0000.
REQ-033 Back-to-back 3 inputs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, res stable; then out_ready=1 -> all 3 results in order, none lost.
REQ-034 rst pulsed 1 cycle with 2 ops in flight -> out_valid=0 the next cycle; no old result ever appears.
